// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: circular sample delay line, coefficient RAM and
// one shared signed MAC stepped over all taps per accepted input sample.
module fir_mac_sequencer #(
  parameter int N_TAPS    = 16,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int AW        = 36,
  parameter int OUT_SHIFT = 15
) (
  input  logic                          CLOCK_50,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DW-1:0]          in_data,
  input  logic                          coef_we,
  input  logic [$clog2(N_TAPS)-1:0]     coef_addr,
  input  logic signed [CW-1:0]          coef_data,
  output logic                          coef_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DW-1:0]          out_data,
  output logic                          sat_flag,
  output logic                          busy
);

  localparam int TW = $clog2(N_TAPS);
  localparam int PW = DW + CW;

  localparam logic signed [15:0] DEFAULT_COEF [16] = '{
    -16'sd81,   -16'sd134,  16'sd318,   16'sd645,
    -16'sd1257, -16'sd2262, 16'sd4522,  16'sd14633,
    16'sd14633, 16'sd4522,  -16'sd2262, -16'sd1257,
    16'sd645,   16'sd318,   -16'sd134,  -16'sd81
  };

  localparam logic signed [AW-1:0] RND     = AW'(1) << (OUT_SHIFT - 1);
  localparam logic signed [AW-1:0] OUT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] OUT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

  state_t                state, state_nx;
  logic signed [DW-1:0]  dly  [N_TAPS];
  logic signed [CW-1:0]  coef [N_TAPS];
  logic [TW-1:0]         wr_ptr;
  logic [TW-1:0]         tap;
  logic signed [AW-1:0]  acc;

  logic [TW-1:0]         rd_idx;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  acc_rnd;
  logic signed [AW-1:0]  r;
  logic                  last_tap;

  // Newest sample sits at wr_ptr; tap k reaches k samples back, wrapping mod N_TAPS.
  assign rd_idx   = wr_ptr - tap;
  assign prod     = coef[tap] * dly[rd_idx];
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign acc_rnd  = acc + RND;
  assign r        = acc_rnd >>> OUT_SHIFT;
  assign last_tap = (tap == TW'(N_TAPS - 1));

  // Status outputs depend on state only, so no path from in_valid/out_ready.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign coef_err = coef_we && (state != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = MAC;
      MAC:     if (last_tap)  state_nx = ROUND;
      ROUND:                  state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // NOTE: delay line and coefficient RAM are flop arrays because reset must zero/reload
  // them; a reset cannot be applied to an inferred block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        dly[i]  <= '0;
        coef[i] <= CW'(DEFAULT_COEF[4'(i)]);
      end
      wr_ptr    <= '0;
      tap       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we) coef[coef_addr] <= coef_data;
          if (in_valid) begin
            dly[wr_ptr] <= in_data;
            acc         <= '0;
            tap         <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          tap <= tap + TW'(1);
          if (last_tap) wr_ptr <= wr_ptr + TW'(1);
        end
        ROUND: begin
          out_valid <= 1'b1;
          if (r > OUT_MAX) begin
            out_data <= {1'b0, {(DW-1){1'b1}}};
            sat_flag <= 1'b1;
          end else if (r < OUT_MIN) begin
            out_data <= {1'b1, {(DW-1){1'b0}}};
            sat_flag <= 1'b1;
          end else begin
            out_data <= r[DW-1:0];
            sat_flag <= 1'b0;
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: randomized samples/coefficients scored
// against a direct-form convolution model with round-half-up and saturation.
module tb_fir_mac_sequencer;

  localparam int N = 16;

  logic               CLOCK_50 = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_err;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               sat_flag;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  int mcoef [N];
  int hist  [N];
  int dflt  [N] = '{-81, -134, 318, 645, -1257, -2262, 4522, 14633,
                    14633, 4522, -2262, -1257, 645, 318, -134, -81};

  always #5 CLOCK_50 = ~CLOCK_50;

  fir_mac_sequencer dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mcoef[i] = dflt[i];
      hist[i]  = 0;
    end
  endfunction

  // y = sat(round_half_up(sum_k coef[k] * x[n-k] / 2^15))
  function automatic void model_expect(output int d, output bit s);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(mcoef[k]) * longint'(hist[k]);
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767)       begin d = 32767;  s = 1'b1; end
    else if (r < -32768) begin d = -32768; s = 1'b1; end
    else                 begin d = int'(r); s = 1'b0; end
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Accept one sample (optionally with a same-cycle coefficient write) and score it.
  // Entered and left just after a falling edge.
  task automatic send(input int d, input bit we, input int addr, input int val,
                      input string name, output int got, output bit gsat);
    int n;
    int ed;
    bit es;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_timeout got=%b want=1", name, in_ready);
      got  = 0;
      gsat = 1'b0;
      return;
    end
    in_valid  = 1'b1;
    in_data   = 16'(d);
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_data = 16'(val);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (we) mcoef[addr] = val;
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    model_expect(ed, es);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (n !== 18) begin
      failures++;
      $display("FAIL %s latency got=%0d want=18", name, n);
    end
    got  = int'(out_data);
    gsat = sat_flag;
    checks++;
    if (got !== ed) begin
      failures++;
      $display("FAIL %s out_data got=%0d want=%0d", name, got, ed);
    end
    checks++;
    if (gsat !== es) begin
      failures++;
      $display("FAIL %s sat_flag got=%b want=%b", name, gsat, es);
    end
    if (out_ready) begin
      @(negedge CLOCK_50);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 16'(val);
    #1;
    checks++;
    if (coef_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_coef_write coef_err got=%b want=0", coef_err);
    end
    @(negedge CLOCK_50);
    coef_we = 1'b0;
    mcoef[addr] = val;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({in_ready, busy, out_valid, sat_flag, coef_err} !== 5'b10000 || out_data !== 16'sd0) begin
      failures++;
      $display("FAIL reset_state rdy/busy/ov/sat/err got=%b%b%b%b%b data=%0d want=10000 data=0",
               in_ready, busy, out_valid, sat_flag, coef_err, out_data);
    end
  endtask

  task automatic test_impulse(input string name);
    int got;
    bit gs;
    for (int k = 0; k < N; k++) begin
      send((k == 0) ? 32767 : 0, 1'b0, 0, 0, name, got, gs);
      checks++;
      if (got !== dflt[k] || gs !== 1'b0) begin
        failures++;
        $display("FAIL %s tap%0d got=%0d/%b want=%0d/0", name, k, got, gs, dflt[k]);
      end
    end
  endtask

  task automatic test_rounding();
    int got;
    bit gs;
    for (int i = 0; i < N; i++) write_coef(i, (i == 0) ? 16384 : 0);
    send(1000, 1'b0, 0, 0, "round_pos", got, gs);
    send(-7, 1'b0, 0, 0, "round_neg", got, gs);
    // Coefficient written in the handshake cycle must be used by that sample.
    send(1000, 1'b1, 0, 8192, "coef_same_cycle", got, gs);
    checks++;
    if (got !== 250) begin
      failures++;
      $display("FAIL coef_same_cycle_direct got=%0d want=250", got);
    end
  endtask

  task automatic test_hold();
    int got;
    bit gs;
    logic signed [15:0] held;
    logic held_sat;
    out_ready = 1'b0;
    send(rand_s16(), 1'b0, 0, 0, "hold_sample", got, gs);
    held     = out_data;
    held_sat = sat_flag;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || sat_flag !== held_sat ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable cyc%0d ov=%b data=%0d rdy=%b busy=%b want 1/%0d/0/1",
                 i, out_valid, out_data, in_ready, busy, held);
      end
      if (i == 3) begin
        coef_we = 1'b1; coef_addr = 4'd3; coef_data = 16'sd1234;
        #1;
        checks++;
        if (coef_err !== 1'b1) begin
          failures++;
          $display("FAIL busy_coef_err got=%b want=1", coef_err);
        end
      end else if (i == 4) begin
        coef_we = 1'b0;
        #1;
        checks++;
        if (coef_err !== 1'b0) begin
          failures++;
          $display("FAIL coef_err_pulse got=%b want=0", coef_err);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    // Model coefficients untouched: any stray write to coef[3] shows up here.
    for (int i = 0; i < 4; i++) send(rand_s16(), 1'b0, 0, 0, "ram_unchanged", got, gs);
  endtask

  task automatic test_saturation();
    int got;
    bit gs;
    for (int i = 0; i < N; i++) write_coef(i, 32767);
    for (int i = 0; i < N; i++) send(32767, 1'b0, 0, 0, "sat_pos", got, gs);
    checks++;
    if (got !== 32767 || gs !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos_final got=%0d/%b want=32767/1", got, gs);
    end
    for (int i = 0; i < N; i++) send(-32768, 1'b0, 0, 0, "sat_neg", got, gs);
    checks++;
    if (got !== -32768 || gs !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg_final got=%0d/%b want=-32768/1", got, gs);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    bit gs;
    for (int i = 0; i < N; i++) write_coef(i, rand_s16() / 4);
    for (int i = 0; i < 20; i++) send(rand_s16(), 1'b0, 0, 0, "conv_random", got, gs);
  endtask

  task automatic test_reset_mid_mac();
    int seen;
    in_valid = 1'b1;
    in_data  = 16'sd12345;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    repeat (7) @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({in_ready, busy, out_valid, sat_flag} !== 4'b1000 || out_data !== 16'sd0) begin
      failures++;
      $display("FAIL mid_mac_reset rdy/busy/ov/sat got=%b%b%b%b data=%0d want=1000 data=0",
               in_ready, busy, out_valid, sat_flag, out_data);
    end
    seen = 0;
    repeat (25) begin
      @(negedge CLOCK_50);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL aborted_output out_valid_cycles got=%0d want=0", seen);
    end
    test_impulse("impulse_after_reset");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    test_reset();
    test_impulse("impulse_default");
    test_rounding();
    test_hold();
    test_saturation();
    test_back_to_back();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
